// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
// Shared types and constants for regfile_access_arbiter and its sub-modules.
//   op_e      : request opcode (READ / WRITE / SCAN / reserved)
//   state_e   : arbiter FSM state encoding
//   ERR_CNT_W : width of the optional error counter
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SCAN  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches the request vector
// starting at the pointer position and wrapping around; the first active
// request found gets the one-hot grant.
// Ports:
//   i_req   [NUM_REQ]          request vector
//   i_ptr   [$clog2(NUM_REQ)]  highest-priority requester index
//   o_grant [NUM_REQ]          one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant
);

  always_comb begin
    logic w_found;
    int   w_idx;
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_access_arbiter
// Shares a small register array between NUM_REQ requesters. One request is
// in flight at a time: IDLE grants round-robin, READ/WRITE/reserved ops
// answer in the next cycle, SCAN walks the whole array counting entries that
// match a pattern under a don't-care mask, RESP holds the response until it
// is accepted. Out-of-bounds accesses and the reserved op raise o_rsp_err.
//
// Optional feature: define REGFILE_ARB_ERR_COUNT_EN to add o_err_count, a
// saturating count of accepted responses carrying o_rsp_err.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready   per-requester handshake (ready is one-hot)
//   i_req_op/addr/data/mask   per-requester payload, packed requester-major
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_id/data/err         response payload, stable while o_rsp_valid
//   o_err_count               (REGFILE_ARB_ERR_COUNT_EN only)
// -----------------------------------------------------------------------------
module regfile_access_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int ARR_SIZE = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  output logic [NUM_REQ-1:0]          o_req_ready,
  input  logic [2*NUM_REQ-1:0]        i_req_op,
  input  logic [ADDR_W*NUM_REQ-1:0]   i_req_addr,
  input  logic [DATA_W*NUM_REQ-1:0]   i_req_data,
  input  logic [DATA_W*NUM_REQ-1:0]   i_req_mask,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  o_rsp_id,
  output logic [DATA_W-1:0]           o_rsp_data,
  output logic                        o_rsp_err
`ifdef REGFILE_ARB_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0]        o_err_count
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int IDX_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam int CNT_W = $clog2(ARR_SIZE + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              r_state;
  state_e              w_state_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [DATA_W-1:0]   r_mem [ARR_SIZE];
  logic [ID_W-1:0]     r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_pat;
  logic [DATA_W-1:0]   r_mask;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;

  // ---------------------------------------------------------------------------
  // Request unpacking and arbitration
  // ---------------------------------------------------------------------------
  op_e                 w_op_arr   [NUM_REQ];
  logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   w_data_arr [NUM_REQ];
  logic [DATA_W-1:0]   w_mask_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  w_grant;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_op_arr[gi]    = op_e'(i_req_op[gi*2 +: 2]);
    assign w_addr_arr[gi]  = i_req_addr[gi*ADDR_W +: ADDR_W];
    assign w_data_arr[gi]  = i_req_data[gi*DATA_W +: DATA_W];
    assign w_mask_arr[gi]  = i_req_mask[gi*DATA_W +: DATA_W];
    // Ready depends only on FSM state and the request side, never on the
    // response channel.
    assign o_req_ready[gi] = (r_state == ST_IDLE) && i_req_valid[gi] && w_grant[gi];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  logic [ID_W-1:0] w_gnt_id;
  always_comb begin
    w_gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gnt_id = ID_W'(i);
    end
  end

  logic              w_req_fire;
  op_e               w_sel_op;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic [DATA_W-1:0] w_sel_mask;
  logic              w_sel_in_bounds;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [ID_W-1:0]   w_ptr_next;
  logic              w_write_en;

  assign w_req_fire      = |o_req_ready;
  assign w_sel_op        = w_op_arr[w_gnt_id];
  assign w_sel_addr      = w_addr_arr[w_gnt_id];
  assign w_sel_data      = w_data_arr[w_gnt_id];
  assign w_sel_mask      = w_mask_arr[w_gnt_id];
  // Extra leading zero keeps the compare correct when ARR_SIZE == 2**ADDR_W.
  assign w_sel_in_bounds = ({1'b0, w_sel_addr} < (ADDR_W+1)'(ARR_SIZE));
  assign w_sel_idx       = w_sel_addr[IDX_W-1:0];
  assign w_ptr_next      = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
  assign w_write_en      = w_req_fire && (w_sel_op == OP_WRITE) && w_sel_in_bounds;

  // ---------------------------------------------------------------------------
  // Scan datapath: one entry per cycle, count includes the current hit
  // ---------------------------------------------------------------------------
  logic              w_scan_hit;
  logic              w_scan_last;
  logic [CNT_W-1:0]  w_cnt_sum;

  assign w_scan_hit  = (((r_mem[r_idx] ^ r_pat) & ~r_mask) == '0);
  assign w_scan_last = (r_idx == IDX_W'(ARR_SIZE - 1));
  assign w_cnt_sum   = r_cnt + CNT_W'(w_scan_hit);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_fire) w_state_next = (w_sel_op == OP_SCAN) ? ST_SCAN : ST_RESP;
      end
      ST_SCAN: begin
        if (w_scan_last) w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register array: only a WRITE handshake changes contents
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < ARR_SIZE; gi++) begin : g_mem
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                                      r_mem[gi] <= '0;
      else if (w_write_en && (w_sel_idx == IDX_W'(gi)))  r_mem[gi] <= w_sel_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_pat      <= '0;
      r_mask     <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_rsp_id <= w_gnt_id;
            r_rr_ptr <= w_ptr_next;
            r_pat    <= w_sel_data;
            r_mask   <= w_sel_mask;
            r_idx    <= '0;
            r_cnt    <= '0;
            case (w_sel_op)
              OP_READ: begin
                r_rsp_data <= w_sel_in_bounds ? r_mem[w_sel_idx] : '0;
                r_rsp_err  <= !w_sel_in_bounds;
              end
              OP_WRITE: begin
                r_rsp_data <= w_sel_in_bounds ? w_sel_data : '0;
                r_rsp_err  <= !w_sel_in_bounds;
              end
              OP_SCAN: begin
                r_rsp_err  <= 1'b0;
              end
              OP_RSVD: begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
              end
            endcase
          end
        end
        ST_SCAN: begin
          r_cnt <= w_cnt_sum;
          r_idx <= r_idx + IDX_W'(1);
          if (w_scan_last) begin
            r_rsp_data <= DATA_W'(w_cnt_sum);
            r_rsp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

`ifdef REGFILE_ARB_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (o_rsp_valid && i_rsp_ready && r_rsp_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign o_err_count = r_err_cnt;
`endif

endmodule
